// File: rtl/layer_sequencer_pkg.sv
// Shared definitions for the layer sequencer: controller state encoding,
// activation word width and width helpers used to size counters.
package layer_sequencer_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Ceiling log2; clog2(0) and clog2(1) are 0.
    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return r;
    endfunction

    // Width that can hold 0..v-1, never narrower than one bit.
    function automatic int width_of(input int v);
        return (clog2(v) < 1) ? 1 : clog2(v);
    endfunction

endpackage

// File: rtl/layer_sequencer_cycle_counter.sv
// cycle_counter: up-counter that clears to zero on clr, counts on en and
// flags when the count equals tc_val.
// Ports: clk, rst_n (async low), clr, en, tc_val[W] in; tc out.
module cycle_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] tc_val,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= count + 1'b1;
    end

    assign tc = (count == tc_val);

endmodule

// File: rtl/layer_sequencer.sv
// layer_sequencer: runs NUM_LAYERS fully connected layers through one shared
// neural-layer datapath. Latches in_vec, launches a datapath run per layer,
// waits for dp_done plus a settle window, captures dp_result into act_reg and
// feeds it back as the next layer input.
// Ports: clk, rst_n, start, abort, in_vec in; busy, done, error, result,
// layer_idx out; dp_start, dp_in out / dp_done, dp_result in (datapath side).
module layer_sequencer
    import layer_sequencer_pkg::*;
#(
    parameter int SIZE          = 4,
    parameter int NUM_LAYERS    = 3,
    parameter int SETTLE_CYCLES = 2,
    parameter int TIMEOUT       = 1024,
    localparam int LW           = width_of(NUM_LAYERS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    input  logic [SIZE-1:0][WORD_W-1:0]  in_vec,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic [SIZE-1:0][WORD_W-1:0]  result,
    output logic [LW-1:0]                layer_idx,
    output logic                         dp_start,
    output logic [SIZE-1:0][WORD_W-1:0]  dp_in,
    input  logic                         dp_done,
    input  logic [SIZE-1:0][WORD_W-1:0]  dp_result
);

    localparam int WW = width_of(TIMEOUT);
    localparam int SW = width_of(SETTLE_CYCLES);
    localparam logic [WW-1:0] WAIT_TC    = WW'(TIMEOUT - 1);
    localparam logic [SW-1:0] SETTLE_TC  = SW'(SETTLE_CYCLES - 1);
    localparam logic [LW-1:0] LAST_LAYER = LW'(NUM_LAYERS - 1);
    localparam bit            TO_EN      = (TIMEOUT != 0);

    state_t state, state_nx;
    logic [SIZE-1:0][WORD_W-1:0] act_reg;

    logic load_in, capture, step_layer, set_err;
    logic wait_clr, wait_en, wait_tc;
    logic settle_clr, settle_en, settle_tc;

    cycle_counter #(.W(WW)) wait_cnt (
        .clk(clk), .rst_n(rst_n), .clr(wait_clr), .en(wait_en),
        .tc_val(WAIT_TC), .tc(wait_tc)
    );

    cycle_counter #(.W(SW)) settle_cnt (
        .clk(clk), .rst_n(rst_n), .clr(settle_clr), .en(settle_en),
        .tc_val(SETTLE_TC), .tc(settle_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        dp_start   = 1'b0;
        done       = 1'b0;
        load_in    = 1'b0;
        capture    = 1'b0;
        step_layer = 1'b0;
        set_err    = 1'b0;
        wait_clr   = 1'b0;
        wait_en    = 1'b0;
        settle_clr = 1'b0;
        settle_en  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load_in  = 1'b1;
                    state_nx = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // dp_done may still be high from the previous layer; ignore it here.
                dp_start = 1'b1;
                wait_clr = 1'b1;
                state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                // dp_done outranks a timeout expiring in the same cycle.
                if (dp_done) begin
                    settle_clr = 1'b1;
                    state_nx   = ST_SETTLE;
                end else if (TO_EN && wait_tc) begin
                    set_err  = 1'b1;
                    state_nx = ST_IDLE;
                end else begin
                    wait_en = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (settle_tc) begin
                    capture = 1'b1;
                    if (layer_idx == LAST_LAYER) begin
                        state_nx = ST_DONE;
                    end else begin
                        step_layer = 1'b1;
                        state_nx   = ST_ISSUE;
                    end
                end else begin
                    settle_en = 1'b1;
                end
            end
            ST_DONE: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
        // Abort freezes act_reg, error and layer_idx and drops any pulse.
        if (abort) begin
            state_nx   = ST_IDLE;
            dp_start   = 1'b0;
            done       = 1'b0;
            load_in    = 1'b0;
            capture    = 1'b0;
            step_layer = 1'b0;
            set_err    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_reg   <= '0;
            layer_idx <= '0;
            error     <= 1'b0;
        end else begin
            if (load_in) begin
                act_reg   <= in_vec;
                layer_idx <= '0;
                error     <= 1'b0;
            end
            if (capture)
                act_reg <= dp_result;
            if (step_layer)
                layer_idx <= layer_idx + 1'b1;
            if (set_err)
                error <= 1'b1;
        end
    end

    assign busy   = (state != ST_IDLE);
    assign result = act_reg;
    assign dp_in  = act_reg;

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: three instances (default config, TIMEOUT=8 with a
// silent datapath, NUM_LAYERS=1/SETTLE_CYCLES=1 with a one-cycle datapath).
// Expected cycles and results come from the timing formula L=1+D+SETTLE and
// the stub rule "each layer adds 1 to every word".
module tb_layer_sequencer;
    typedef logic [3:0][31:0] vec_t;

    logic clk, rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    // ---------------- instance A: defaults ----------------
    logic start_a, abort_a, busy_a, done_a, err_a, dps_a, dpd_a;
    vec_t in_a, res_a, dpi_a, dpr_a;
    logic [1:0] lidx_a;
    int   d_a = 5;
    int   cnt_a;

    layer_sequencer u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .in_vec(in_a),
        .busy(busy_a), .done(done_a), .error(err_a), .result(res_a), .layer_idx(lidx_a),
        .dp_start(dps_a), .dp_in(dpi_a), .dp_done(dpd_a), .dp_result(dpr_a)
    );

    // Stub datapath: dp_done rises D cycles after the dp_start cycle and stays
    // high until the next dp_start.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a <= 0;
            dpd_a <= 1'b0;
        end else if (dps_a) begin
            cnt_a <= d_a - 1;
            dpd_a <= (d_a == 1);
        end else if (cnt_a > 0) begin
            cnt_a <= cnt_a - 1;
            if (cnt_a == 1) dpd_a <= 1'b1;
        end
    end
    always_comb for (int i = 0; i < 4; i++) dpr_a[i] = dpi_a[i] + 32'd1;

    // ---------------- instance B: TIMEOUT=8, no dp_done ----------------
    logic start_b, busy_b, done_b, err_b, dps_b;
    vec_t in_b, res_b, dpi_b;
    logic [1:0] lidx_b;

    layer_sequencer #(.TIMEOUT(8)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(1'b0), .in_vec(in_b),
        .busy(busy_b), .done(done_b), .error(err_b), .result(res_b), .layer_idx(lidx_b),
        .dp_start(dps_b), .dp_in(dpi_b), .dp_done(1'b0), .dp_result('0)
    );

    // ---------------- instance C: 1 layer, 1 settle, D=1 ----------------
    logic start_c, busy_c, done_c, err_c, dps_c, dpd_c;
    vec_t in_c, res_c, dpi_c, dpr_c;
    logic [0:0] lidx_c;

    layer_sequencer #(.NUM_LAYERS(1), .SETTLE_CYCLES(1)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .abort(1'b0), .in_vec(in_c),
        .busy(busy_c), .done(done_c), .error(err_c), .result(res_c), .layer_idx(lidx_c),
        .dp_start(dps_c), .dp_in(dpi_c), .dp_done(dpd_c), .dp_result(dpr_c)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) dpd_c <= 1'b0;
        else        dpd_c <= dps_c;
    end
    always_comb for (int i = 0; i < 4; i++) dpr_c[i] = dpi_c[i] + 32'd1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference helpers ----------------
    int   starts_q[$];
    int   lidx_q[$];
    int   done_q[$];
    logic busy_log[0:63];

    function automatic vec_t plus_n(input vec_t v, input int n);
        vec_t r;
        for (int i = 0; i < 4; i++) r[i] = v[i] + 32'(n);
        return r;
    endfunction

    function automatic vec_t rand_vec();
        vec_t r;
        for (int i = 0; i < 4; i++) r[i] = $urandom();
        return r;
    endfunction

    task automatic chk_i(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_v(input string tag, input vec_t obs, input vec_t exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Start a run on A (DUT idle, called mid-cycle) and log ncyc cycles.
    task automatic run_a(input vec_t v, input int d, input int ncyc,
                         input int abort_cyc, input int extra_start);
        d_a = d;
        in_a = v;
        starts_q.delete(); lidx_q.delete(); done_q.delete();
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        for (int k = 1; k <= ncyc; k++) begin
            abort_a = (k == abort_cyc);
            start_a = (k == extra_start);
            #1;
            if (dps_a) begin
                starts_q.push_back(k);
                lidx_q.push_back(int'(lidx_a));
            end
            if (done_a) done_q.push_back(k);
            busy_log[k] = busy_a;
            @(posedge clk); #1;
        end
        abort_a = 1'b0;
        start_a = 1'b0;
    endtask

    task automatic check_run(input string p, input vec_t v, input int d);
        int L;
        L = 3 + d;
        chk_i({p, " done_count"}, done_q.size(), 1);
        if (done_q.size() > 0) chk_i({p, " done_cycle"}, done_q[0], 1 + 3 * L);
        chk_i({p, " dp_start_count"}, starts_q.size(), 3);
        for (int i = 0; i < starts_q.size() && i < 3; i++) begin
            chk_i({p, " dp_start_cycle"}, starts_q[i], 1 + i * L);
            chk_i({p, " layer_idx_at_start"}, lidx_q[i], i);
        end
        chk_i({p, " busy_in_done"}, 32'(busy_log[1 + 3 * L]), 1);
        chk_i({p, " busy_after_done"}, 32'(busy_log[2 + 3 * L]), 0);
        chk_v({p, " result"}, res_a, plus_n(v, 3));
        chk_i({p, " layer_idx_hold"}, 32'(lidx_a), 2);
    endtask

    initial begin
        vec_t v;
        int   d;
        int   dn;
        rst_n = 1'b0;
        start_a = 0; abort_a = 0; start_b = 0; start_c = 0;
        in_a = '0; in_b = '0; in_c = '0;
        #12;
        // reset state
        chk_i("rst busy", 32'(busy_a), 0);
        chk_i("rst done", 32'(done_a), 0);
        chk_i("rst error", 32'(err_a), 0);
        chk_i("rst dp_start", 32'(dps_a), 0);
        chk_i("rst layer_idx", 32'(lidx_a), 0);
        chk_v("rst result", res_a, '0);
        chk_v("rst dp_in", dpi_a, '0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // nominal run
        v = {4{32'h10}};
        run_a(v, 5, 27, 0, 0);
        check_run("nominal", v, 5);
        chk_v("nominal result_abs", res_a, {4{32'h13}});

        // start while busy
        v = rand_vec();
        run_a(v, 5, 27, 0, 10);
        check_run("start_busy", v, 5);

        // abort in SETTLE of layer 1 (cycles 15..16)
        v = rand_vec();
        run_a(v, 5, 27, 15, 0);
        chk_i("abort busy_before", 32'(busy_log[15]), 1);
        chk_i("abort idle_next", 32'(busy_log[16]), 0);
        chk_i("abort no_done", done_q.size(), 0);
        chk_i("abort dp_starts", starts_q.size(), 2);
        chk_v("abort act_kept", res_a, plus_n(v, 1));
        chk_i("abort layer_kept", 32'(lidx_a), 1);
        v = rand_vec();
        run_a(v, 5, 27, 0, 0);
        check_run("after_abort", v, 5);

        // async reset mid-WAIT
        v = rand_vec();
        d_a = 5; in_a = v;
        start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk_i("arst busy", 32'(busy_a), 0);
        chk_i("arst dp_start", 32'(dps_a), 0);
        chk_i("arst done", 32'(done_a), 0);
        chk_i("arst layer_idx", 32'(lidx_a), 0);
        chk_v("arst result", res_a, '0);
        chk_v("arst dp_in", dpi_a, '0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        v = {4{32'h10}};
        run_a(v, 5, 27, 0, 0);
        check_run("after_reset", v, 5);

        // randomized runs
        for (int r = 0; r < 4; r++) begin
            v = rand_vec();
            d = int'($urandom_range(10, 2));
            run_a(v, d, 3 + 3 * (3 + d), 0, 0);
            check_run($sformatf("rand%0d_d%0d", r, d), v, d);
        end

        // timeout on B
        in_b = rand_vec();
        start_b = 1'b1;
        @(posedge clk); #1; start_b = 1'b0;
        dn = 0;
        for (int k = 1; k <= 12; k++) begin
            if (done_b) dn++;
            if (k == 9) begin
                chk_i("tmo busy_wait8", 32'(busy_b), 1);
                chk_i("tmo error_wait8", 32'(err_b), 0);
            end
            if (k == 10) begin
                chk_i("tmo busy_after", 32'(busy_b), 0);
                chk_i("tmo error_after", 32'(err_b), 1);
            end
            @(posedge clk); #1;
        end
        chk_i("tmo no_done", dn, 0);
        chk_i("tmo error_sticky", 32'(err_b), 1);
        chk_v("tmo act_kept", res_b, in_b);
        start_b = 1'b1;
        @(posedge clk); #1; start_b = 1'b0;
        chk_i("tmo restart_error_clr", 32'(err_b), 0);
        chk_i("tmo restart_dp_start", 32'(dps_b), 1);
        repeat (12) @(posedge clk);
        #1;

        // edge configuration on C
        v = rand_vec();
        in_c = v;
        start_c = 1'b1;
        @(posedge clk); #1; start_c = 1'b0;
        dn = 0;
        for (int k = 1; k <= 7; k++) begin
            start_c = (k == 5);
            #1;
            if (k == 1) chk_i("edge dp_start_c1", 32'(dps_c), 1);
            if (k == 4) chk_i("edge done_c4", 32'(done_c), 1);
            if (done_c) dn++;
            if (k == 5) begin
                chk_v("edge result", res_c, plus_n(v, 1));
                chk_i("edge idle_c5", 32'(busy_c), 0);
            end
            if (k == 6) chk_i("edge b2b_dp_start", 32'(dps_c), 1);
            @(posedge clk); #1;
        end
        start_c = 1'b0;
        chk_i("edge done_count", dn, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
